// File: rtl/alarm_pkg.sv
// Shared state encoding, default timing constants and width helper for the alarm ring sequencer.
package alarm_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RINGING = 2'b01;
  localparam logic [1:0] ST_SNOOZE  = 2'b10;

  localparam int unsigned RING_TIMEOUT_S_DEF = 60;
  localparam int unsigned SNOOZE_S_DEF       = 300;
  localparam int unsigned MAX_SNOOZES_DEF    = 3;
  localparam int unsigned BEEP_HALF_DEF      = 50;

  // Counter width for a modulo-n timer, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alarm_ring_sequencer_tick_mod_counter.sv
// Modulo-N counter advanced by a tick enable; last flags the terminal count N-1.
module tick_mod_counter
  import alarm_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         tick,
  output logic [W-1:0] cnt,
  output logic         last
);

  assign last = (cnt == W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= last ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/alarm_ring_sequencer.sv
// Alarm ring sequencer: beep pattern, snooze handling, ring timeout and stop.
// Optional build macro ALARM_AUTO_SNOOZE_EN turns ring timeouts into automatic snoozes.
module alarm_ring_sequencer
  import alarm_pkg::*;
#(
  parameter int unsigned RING_TIMEOUT_S = RING_TIMEOUT_S_DEF,
  parameter int unsigned SNOOZE_S       = SNOOZE_S_DEF,
  parameter int unsigned MAX_SNOOZES    = MAX_SNOOZES_DEF,
  parameter int unsigned BEEP_HALF      = BEEP_HALF_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_fast,
  input  logic       armed,
  input  logic       time_match,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  output logic       buzz,
  output logic       led,
  output logic [1:0] state_o,
  output logic [1:0] snooze_cnt,
  output logic       timed_out
);

  localparam int unsigned BEEP_W = cnt_width(BEEP_HALF);
  localparam int unsigned RING_W = cnt_width(RING_TIMEOUT_S);
  localparam int unsigned SNZ_W  = cnt_width(SNOOZE_S);

  logic [1:0] r_state, r_snooze_cnt;
  logic       r_beep_phase, r_led, r_buzz, r_timed_out, r_match_q;

  logic [1:0] w_state_nx, w_snooze_cnt_nx;
  logic       w_phase_nx, w_led_nx, w_timed_out_nx;
  logic       w_enter_ring, w_enter_snz;
  logic       w_match_rise, w_snz_avail;
  logic       w_beep_tick, w_ring_tick, w_snz_tick;
  logic       w_beep_last, w_ring_last, w_snz_last;
  logic       w_beep_wrap, w_timeout, w_snz_expire;

  logic [BEEP_W-1:0] w_beep_cnt;
  logic [RING_W-1:0] w_ring_cnt;
  logic [SNZ_W-1:0]  w_snz_cnt;
  logic              w_unused;

  // Timer counts are observed only through their terminal flags.
  assign w_unused = ^{w_beep_cnt, w_ring_cnt, w_snz_cnt};

  assign w_match_rise = time_match & ~r_match_q;
  assign w_snz_avail  = (r_snooze_cnt < 2'(MAX_SNOOZES));
  assign w_beep_tick  = tick_fast & (r_state == ST_RINGING);
  assign w_ring_tick  = tick_1hz & (r_state == ST_RINGING);
  assign w_snz_tick   = tick_1hz & (r_state == ST_SNOOZE);
  assign w_beep_wrap  = w_beep_tick & w_beep_last;
  assign w_timeout    = w_ring_tick & w_ring_last;
  assign w_snz_expire = w_snz_tick & w_snz_last;

  tick_mod_counter #(.N(BEEP_HALF)) u_beep (
    .clk(clk), .rst_n(rst_n), .clr(w_enter_ring), .tick(w_beep_tick),
    .cnt(w_beep_cnt), .last(w_beep_last)
  );

  tick_mod_counter #(.N(RING_TIMEOUT_S)) u_ring (
    .clk(clk), .rst_n(rst_n), .clr(w_enter_ring), .tick(w_ring_tick),
    .cnt(w_ring_cnt), .last(w_ring_last)
  );

  tick_mod_counter #(.N(SNOOZE_S)) u_snooze (
    .clk(clk), .rst_n(rst_n), .clr(w_enter_snz), .tick(w_snz_tick),
    .cnt(w_snz_cnt), .last(w_snz_last)
  );

  // Next state, snooze bookkeeping and next-cycle output values.
  always_comb begin
    w_state_nx      = r_state;
    w_snooze_cnt_nx = r_snooze_cnt;
    w_phase_nx      = r_beep_phase;
    w_led_nx        = 1'b0;
    w_timed_out_nx  = 1'b0;
    w_enter_ring    = 1'b0;
    w_enter_snz     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (armed & w_match_rise) begin
          w_state_nx      = ST_RINGING;
          w_snooze_cnt_nx = '0;
          w_enter_ring    = 1'b1;
        end
      end
      ST_RINGING: begin
        if (w_beep_wrap) w_phase_nx = ~r_beep_phase;
        if (btn_stop | ~armed) begin
          w_state_nx = ST_IDLE;
        end else if (btn_snooze & w_snz_avail) begin
          w_state_nx      = ST_SNOOZE;
          w_snooze_cnt_nx = r_snooze_cnt + 2'd1;
          w_enter_snz     = 1'b1;
        end else if (w_timeout) begin
`ifdef ALARM_AUTO_SNOOZE_EN
          if (w_snz_avail) begin
            w_state_nx      = ST_SNOOZE;
            w_snooze_cnt_nx = r_snooze_cnt + 2'd1;
            w_enter_snz     = 1'b1;
          end else begin
            w_state_nx     = ST_IDLE;
            w_timed_out_nx = 1'b1;
          end
`else
          w_state_nx     = ST_IDLE;
          w_timed_out_nx = 1'b1;
`endif
        end
      end
      ST_SNOOZE: begin
        if (btn_stop | ~armed) begin
          w_state_nx = ST_IDLE;
        end else if (w_snz_expire) begin
          w_state_nx   = ST_RINGING;
          w_enter_ring = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    if (w_enter_ring) w_phase_nx = 1'b1;
    case (w_state_nx)
      ST_RINGING: w_led_nx = w_phase_nx;
      ST_SNOOZE:  w_led_nx = w_enter_snz ? 1'b0 : (r_led ^ tick_1hz);
      default:    w_led_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_snooze_cnt <= '0;
      r_beep_phase <= 1'b0;
      r_led        <= 1'b0;
      r_buzz       <= 1'b0;
      r_timed_out  <= 1'b0;
      r_match_q    <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_snooze_cnt <= w_snooze_cnt_nx;
      r_beep_phase <= w_phase_nx;
      r_led        <= w_led_nx;
      r_buzz       <= (w_state_nx == ST_RINGING) & w_phase_nx;
      r_timed_out  <= w_timed_out_nx;
      r_match_q    <= time_match;
    end
  end

  assign buzz       = r_buzz;
  assign led        = r_led;
  assign state_o    = r_state;
  assign snooze_cnt = r_snooze_cnt;
  assign timed_out  = r_timed_out;

endmodule
